// File: rtl/led_pwm_fader.sv
// Per-channel PWM brightness ramp between the pattern generator and the board LEDs.
// Levels step toward the latched target on each step tick, saturating at 0 and MAX.
module led_pwm_fader #(
  parameter int unsigned NUM_LEDS    = 5,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 23529
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NUM_LEDS-1:0] pattern,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy
);

  localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX - PWM_BITS'(1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RISING,
    CH_ON,
    CH_FALLING
  } ch_state_e;

  logic [NUM_LEDS-1:0] target;
  logic [PWM_BITS-1:0] level     [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0]       step_cnt;
  logic                step;
  ch_state_e           ch_state  [NUM_LEDS];

  assign step = (step_cnt == STEP_LAST);

  // Channel state is decoded from target/level only; no per-channel state register.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      ch_state[i]  = CH_OFF;
      level_nxt[i] = level[i];
      if (target[i]) begin
        ch_state[i] = (level[i] == MAX) ? CH_ON : CH_RISING;
      end else begin
        ch_state[i] = (level[i] == '0) ? CH_OFF : CH_FALLING;
      end
      if (ch_state[i] == CH_RISING || ch_state[i] == CH_FALLING) begin
        busy = 1'b1;
      end
      if (step) begin
        case (ch_state[i])
          CH_RISING:  level_nxt[i] = level[i] + PWM_BITS'(1);
          CH_FALLING: level_nxt[i] = level[i] - PWM_BITS'(1);
          default:    level_nxt[i] = level[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      led      <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
    end else begin
      if (tick) begin
        target <= pattern;
      end
      step_cnt <= step ? '0 : step_cnt + SW'(1);
      pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        level[i] <= level_nxt[i];
        led[i]   <= (level[i] > pwm_cnt);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: vector table over ramps, reversal, reset and tick/step
// collisions, plus hand sequences for idle-after-reset and frozen-level PWM duty.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [4:0] pattern = '0;
  logic [4:0] led;
  logic       busy;
  logic [4:0] led_s;
  logic       busy_s;

  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(.NUM_LEDS(5), .PWM_BITS(4), .STEP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .pattern(pattern), .led(led), .busy(busy)
  );

  // Slow-stepping copy holds each level for 50 cycles so duty can be counted.
  led_pwm_fader #(.NUM_LEDS(5), .PWM_BITS(4), .STEP_CYCLES(50)) dut_slow (
    .clk(clk), .rst(rst), .tick(tick), .pattern(pattern), .led(led_s), .busy(busy_s)
  );

  typedef struct {
    logic        rst;
    logic        tick;
    logic [4:0]  pattern;
    int unsigned cycles;
    logic [4:0]  exp_led;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic r, input logic t, input logic [4:0] p,
                         input int unsigned n, input logic [4:0] el, input logic eb);
    vec_t v;
    v.rst = r; v.tick = t; v.pattern = p; v.cycles = n; v.exp_led = el; v.exp_busy = eb;
    tbl.push_back(v);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic count_high(input int unsigned nedges, output int unsigned hi0,
                            output int unsigned hi_rest);
    hi0 = 0;
    hi_rest = 0;
    for (int unsigned i = 0; i < nedges; i++) begin
      edge1();
      if (led_s[0]) hi0++;
      if (led_s[4:1] != '0) hi_rest++;
    end
  endtask

  initial begin
    int unsigned e;
    int unsigned hi0, hir;

    // Reset then long idle: nothing lights, nothing busy.
    rst = 1'b1;
    for (int unsigned i = 0; i < 3; i++) edge1();
    check("reset led", 32'(led), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      pattern = 5'(i);
      edge1();
      check($sformatf("idle%0d", i), {26'h0, busy, led}, 32'h0);
    end

    // Rows: rst, tick, pattern, edges, led, busy. Phase: edge E0 is the last reset edge,
    // steps land on even edges, pwm_cnt before edge Ek is (k-1) mod 15.
    // Ramp up channel 0 to 15.
    add_vec(1, 0, 5'b00000,  3, 5'b00000, 0);
    add_vec(0, 1, 5'b00001,  1, 5'b00000, 1);  // E1
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 1);  // E2
    add_vec(0, 0, 5'b00000, 13, 5'b00000, 1);  // E15
    add_vec(0, 0, 5'b00000,  1, 5'b00001, 1);  // E16 level 7 > pwm 0
    add_vec(0, 0, 5'b00000, 13, 5'b00001, 1);  // E29 level 14 > pwm 13
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 0);  // E30 reaches 15; led used 14 vs 14
    add_vec(0, 0, 5'b00000,  1, 5'b00001, 0);  // E31
    add_vec(0, 0, 5'b00000, 20, 5'b00001, 0);  // E51 constant on
    // Ramp to 6 then reverse.
    add_vec(1, 0, 5'b00000,  3, 5'b00000, 0);
    add_vec(0, 1, 5'b00001,  1, 5'b00000, 1);  // E1
    add_vec(0, 0, 5'b00000, 11, 5'b00000, 1);  // E12 level 6
    add_vec(0, 1, 5'b00000,  1, 5'b00000, 1);  // E13 target 0
    add_vec(0, 0, 5'b00000,  3, 5'b00001, 1);  // E16 level 5 > 0
    add_vec(0, 0, 5'b00000,  2, 5'b00001, 1);  // E18 level 4 > 2
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 1);  // E19 level 3 vs 3
    add_vec(0, 0, 5'b00000,  4, 5'b00000, 1);  // E23 level 1
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 0);  // E24 level 0
    add_vec(0, 0, 5'b00000, 30, 5'b00000, 0);
    // Reset mid-ramp at level 9, with a tick in the same cycle.
    add_vec(1, 0, 5'b00000,  3, 5'b00000, 0);
    add_vec(0, 1, 5'b00001,  1, 5'b00000, 1);
    add_vec(0, 0, 5'b00000, 17, 5'b00001, 1);  // E18 level 8 > 2
    add_vec(0, 0, 5'b00000,  1, 5'b00001, 1);  // E19 level 9 > 3
    add_vec(1, 1, 5'b11111,  1, 5'b00000, 0);
    add_vec(0, 0, 5'b00000, 40, 5'b00000, 0);
    // Tick coincident with a step: that step uses the old target.
    add_vec(1, 0, 5'b00000,  3, 5'b00000, 0);
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 0);  // E1
    add_vec(0, 1, 5'b11111,  1, 5'b00000, 1);  // E2 step + tick
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 1);  // E3
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 1);  // E4 all levels to 1
    add_vec(0, 0, 5'b00000, 23, 5'b11111, 1);  // E27 level 12 > 11
    add_vec(0, 0, 5'b00000,  1, 5'b00000, 1);  // E28 level 12 vs 12
    add_vec(0, 0, 5'b00000,  3, 5'b11111, 1);  // E31 level 14
    add_vec(0, 0, 5'b00000,  1, 5'b11111, 0);  // E32 all at 15

    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst;
      tick = tbl[r].tick;
      pattern = tbl[r].pattern;
      for (int unsigned c = 0; c < tbl[r].cycles; c++) begin
        edge1();
        tick = 1'b0;
        pattern = ~tbl[r].pattern;
      end
      check($sformatf("row%0d led", r), 32'(led), 32'(tbl[r].exp_led));
      check($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].exp_busy));
    end

    // Frozen levels on the slow copy: steps every 50 edges, level k held for edges 50k+1..50k+50.
    rst = 1'b1;
    tick = 1'b0;
    for (int unsigned i = 0; i < 3; i++) edge1();
    rst = 1'b0;
    tick = 1'b1;
    pattern = 5'b00001;
    edge1();
    e = 1;
    tick = 1'b0;
    pattern = 5'b11110;
    while (e < 159) begin edge1(); e++; end
    count_high(15, hi0, hir);
    e += 15;
    check("duty level3", hi0, 3);
    check("duty level3 other leds", hir, 0);
    while (e < 409) begin edge1(); e++; end
    count_high(15, hi0, hir);
    e += 15;
    check("duty level8 a", hi0, 8);
    check("duty level8 other leds", hir, 0);
    count_high(15, hi0, hir);
    e += 15;
    check("duty level8 b", hi0, 8);
    check("slow busy", 32'(busy_s), 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
